// File: rtl/ibex_pkg.sv
// Shared types for the EX->WB result buffer: buffered entry record and its parity helper.
package ibex_pkg;

   localparam int unsigned RegAddrW = 5;

   typedef struct packed {
      logic                we;
      logic [RegAddrW-1:0] addr;
      logic [31:0]         data;
   } wb_buf_entry_t;

   localparam wb_buf_entry_t EntryReset = '{we: 1'b0, addr: {RegAddrW{1'b0}}, data: 32'h0000_0000};

   // Odd parity: the returned bit makes the count of ones over {entry, bit} odd.
   function automatic logic wb_buf_parity(input wb_buf_entry_t entry);
      return ~(^entry);
   endfunction

endpackage

// File: rtl/ibex_ex_wb_fwd_mux.sv
// Youngest-match forwarding selector over the buffered EX results, walked oldest to youngest.
module ibex_ex_wb_fwd_mux
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 2,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  wb_buf_entry_t       entries_i [Depth],
   input  logic [PtrW-1:0]     rd_ptr_i,
   input  logic [CntW-1:0]     count_i,
   input  logic [RegAddrW-1:0] fwd_addr_i,
   output logic                fwd_hit_o,
   output logic [31:0]         fwd_data_o
);

   logic [PtrW-1:0] idx_s;
   logic            match_s;

   // Later (younger) matches overwrite earlier ones, so the youngest hit wins.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = 32'h0000_0000;
      idx_s      = rd_ptr_i;
      match_s    = 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
         idx_s      = rd_ptr_i + PtrW'(i);
         match_s    = (CntW'(i) < count_i) && entries_i[idx_s].we &&
                      (entries_i[idx_s].addr == fwd_addr_i) &&
                      (fwd_addr_i != {RegAddrW{1'b0}});
         fwd_hit_o  = fwd_hit_o | match_s;
         fwd_data_o = match_s ? entries_i[idx_s].data : fwd_data_o;
      end
   end

endmodule

// File: rtl/ibex_ex_wb_buffer.sv
// In-order EX->WB result FIFO with decode forwarding lookup and setback/flush discard.
// Optional per-entry odd parity with sticky error flag: IBEX_EX_WB_BUFFER_PARITY_EN.
module ibex_ex_wb_buffer
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned AddrW = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     setback_i,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [31:0]              in_result_i,
   input  logic [AddrW-1:0]         in_rd_addr_i,
   input  logic                     in_rd_we_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [AddrW-1:0]         out_rd_addr_o,
   output logic [31:0]              out_rd_wdata_o,
   output logic                     out_rd_we_o,
   input  logic [AddrW-1:0]         fwd_addr_i,
   output logic                     fwd_hit_o,
   output logic [31:0]              fwd_data_o,
   output logic [$clog2(Depth):0]   count_o
`ifdef IBEX_EX_WB_BUFFER_PARITY_EN
   ,
   output logic                     parity_err_o
`endif
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth) + 1;

   wb_buf_entry_t       entries_r [Depth];
   wb_buf_entry_t       head_s;
   wb_buf_entry_t       new_s;
   logic [PtrW-1:0]     rd_ptr_r;
   logic [PtrW-1:0]     wr_ptr_r;
   logic [CntW-1:0]     count_r;
   logic [RegAddrW-1:0] last_addr_r;
   logic [31:0]         last_data_r;
   logic                push_s;
   logic                pop_s;
   logic                clear_s;

   assign clear_s     = setback_i | flush_i;
   assign in_ready_o  = (count_r < CntW'(Depth));
   assign out_valid_o = (count_r != {CntW{1'b0}});
   assign push_s      = in_valid_i & in_ready_o;
   assign pop_s       = out_valid_o & out_ready_i;
   assign head_s      = entries_r[rd_ptr_r];
   // x0 destinations are stored with we cleared so they never write or forward.
   assign new_s       = '{we:   in_rd_we_i & (in_rd_addr_i != {AddrW{1'b0}}),
                          addr: RegAddrW'(in_rd_addr_i),
                          data: in_result_i};

   // Pointers and occupancy; a flush/setback wins over any handshake in the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_r <= {PtrW{1'b0}};
         wr_ptr_r <= {PtrW{1'b0}};
         count_r  <= {CntW{1'b0}};
      end else if (clear_s) begin
         rd_ptr_r <= {PtrW{1'b0}};
         wr_ptr_r <= {PtrW{1'b0}};
         count_r  <= {CntW{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CntW'(1);
            2'b01:   count_r <= count_r - CntW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Depth); i++) entries_r[i] <= EntryReset;
      end else if (push_s && !clear_s) begin
         entries_r[wr_ptr_r] <= new_s;
      end
   end

   // Remembers the last presented head so addr/data hold once the buffer drains.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_addr_r <= {RegAddrW{1'b0}};
         last_data_r <= 32'h0000_0000;
      end else if (out_valid_o) begin
         last_addr_r <= head_s.addr;
         last_data_r <= head_s.data;
      end
   end

   assign out_rd_addr_o  = AddrW'(out_valid_o ? head_s.addr : last_addr_r);
   assign out_rd_wdata_o = out_valid_o ? head_s.data : last_data_r;
   assign out_rd_we_o    = out_valid_o & head_s.we;
   assign count_o        = count_r;

   ibex_ex_wb_fwd_mux #(
      .Depth (Depth)
   ) u_fwd_mux (
      .entries_i  (entries_r),
      .rd_ptr_i   (rd_ptr_r),
      .count_i    (count_r),
      .fwd_addr_i (RegAddrW'(fwd_addr_i)),
      .fwd_hit_o  (fwd_hit_o),
      .fwd_data_o (fwd_data_o)
   );

`ifdef IBEX_EX_WB_BUFFER_PARITY_EN
   logic [Depth-1:0] par_r;
   logic             par_err_r;
   logic             par_mismatch_s;

   assign par_mismatch_s = out_valid_o & (wb_buf_parity(head_s) != par_r[rd_ptr_r]);

   // Parity bit captured alongside each entry at push time.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         par_r <= {Depth{1'b0}};
      end else if (push_s && !clear_s) begin
         par_r[wr_ptr_r] <= wb_buf_parity(new_s);
      end
   end

   // Sticky error: only reset or setback clears it, a plain flush does not.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         par_err_r <= 1'b0;
      end else if (setback_i) begin
         par_err_r <= 1'b0;
      end else if (par_mismatch_s) begin
         par_err_r <= 1'b1;
      end
   end

   assign parity_err_o = par_err_r;
`endif

endmodule

// File: tb/tb_ibex_ex_wb_buffer.sv
// Scoreboard bench for ibex_ex_wb_buffer: directed pushes queue expectations, a monitor checks pops.
module tb_ibex_ex_wb_buffer;

   localparam int unsigned Depth = 2;
   localparam int unsigned AddrW = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              setback = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_result = 32'h0;
   logic [AddrW-1:0]  in_rd_addr = '0;
   logic              in_rd_we = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [AddrW-1:0]  out_rd_addr;
   logic [31:0]       out_rd_wdata;
   logic              out_rd_we;
   logic [AddrW-1:0]  fwd_addr = '0;
   logic              fwd_hit;
   logic [31:0]       fwd_data;
   logic [$clog2(Depth):0] count;
`ifdef IBEX_EX_WB_BUFFER_PARITY_EN
   logic              parity_err;
`endif

   typedef struct {
      logic [AddrW-1:0] addr;
      logic [31:0]      data;
      logic             we;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   logic [AddrW-1:0] prev_addr;
   logic [31:0]      prev_data;

   ibex_ex_wb_buffer #(.Depth(Depth), .AddrW(AddrW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .setback_i      (setback),
      .flush_i        (flush),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .in_result_i    (in_result),
      .in_rd_addr_i   (in_rd_addr),
      .in_rd_we_i     (in_rd_we),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .out_rd_addr_o  (out_rd_addr),
      .out_rd_wdata_o (out_rd_wdata),
      .out_rd_we_o    (out_rd_we),
      .fwd_addr_i     (fwd_addr),
      .fwd_hit_o      (fwd_hit),
      .fwd_data_o     (fwd_data),
      .count_o        (count)
`ifdef IBEX_EX_WB_BUFFER_PARITY_EN
      ,
      .parity_err_o   (parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive(input logic [AddrW-1:0] a, input logic [31:0] d, input logic we);
      in_valid   = 1'b1;
      in_rd_addr = a;
      in_result  = d;
      in_rd_we   = we;
   endtask

   task automatic enq(input logic [AddrW-1:0] a, input logic [31:0] d, input logic we);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.we   = we;
      sb_q.push_back(e);
   endtask

   task automatic pop_n(input int n);
      out_ready = 1'b1;
      repeat (n) begin
         smp();
         cyc();
      end
      out_ready = 1'b0;
   endtask

   // Writeback-side monitor: every accepted head must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got addr %0d data 0x%08h, expected no output", out_rd_addr, out_rd_wdata);
         end else begin
            mon_e = sb_q.pop_front();
            chk("out_addr", 32'(out_rd_addr), 32'(mon_e.addr));
            chk("out_data", out_rd_wdata, mon_e.data);
            chk("out_we", 32'(out_rd_we), 32'(mon_e.we));
         end
      end
      if (setback || flush) sb_q.delete();
   end

   initial begin
      repeat (2) cyc();
      smp();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_we", 32'(out_rd_we), 32'd0);
      chk("rst_addr", 32'(out_rd_addr), 32'd0);
      chk("rst_data", out_rd_wdata, 32'd0);
      chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
      chk("rst_fwd_data", fwd_data, 32'd0);
`ifdef IBEX_EX_WB_BUFFER_PARITY_EN
      chk("rst_par_err", 32'(parity_err), 32'd0);
`endif
      cyc();
      rst = 1'b0;
      smp();
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Single push, visible next cycle and forwardable.
      cyc();
      drive(5'd5, 32'hDEAD_BEEF, 1'b1);
      enq(5'd5, 32'hDEAD_BEEF, 1'b1);
      cyc();
      in_valid = 1'b0;
      fwd_addr = 5'd5;
      smp();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_addr", 32'(out_rd_addr), 32'd5);
      chk("t1_data", out_rd_wdata, 32'hDEAD_BEEF);
      chk("t1_we", 32'(out_rd_we), 32'd1);
      chk("t1_count", 32'(count), 32'd1);
      chk("t1_fwd_hit", 32'(fwd_hit), 32'd1);
      chk("t1_fwd_data", fwd_data, 32'hDEAD_BEEF);
      cyc();
      pop_n(1);
      smp();
      chk("t1_empty_valid", 32'(out_valid), 32'd0);
      chk("t1_empty_we", 32'(out_rd_we), 32'd0);
      chk("t1_hold_data", out_rd_wdata, 32'hDEAD_BEEF);
      chk("t1_hold_addr", 32'(out_rd_addr), 32'd5);
      chk("t1_empty_count", 32'(count), 32'd0);
      chk("t1_empty_fwd", 32'(fwd_hit), 32'd0);
      chk("t1_empty_fwd_data", fwd_data, 32'd0);

      // Fill to Depth, hold off a third push, full+pop refuses the push.
      cyc();
      drive(5'd3, 32'h11, 1'b1);
      enq(5'd3, 32'h11, 1'b1);
      cyc();
      drive(5'd3, 32'h22, 1'b1);
      enq(5'd3, 32'h22, 1'b1);
      cyc();
      drive(5'd3, 32'h33, 1'b1);
      fwd_addr = 5'd3;
      smp();
      chk("t2_count_full", 32'(count), 32'd2);
      chk("t2_ready_full", 32'(in_ready), 32'd0);
      chk("t2_fwd_hit", 32'(fwd_hit), 32'd1);
      chk("t2_fwd_youngest", fwd_data, 32'h22);
      cyc();
      out_ready = 1'b1;
      smp();
      chk("t2_full_pop_ready", 32'(in_ready), 32'd0);
      cyc();
      out_ready = 1'b0;
      smp();
      chk("t2_after_pop_count", 32'(count), 32'd1);
      chk("t2_after_pop_ready", 32'(in_ready), 32'd1);
      enq(5'd3, 32'h33, 1'b1);
      cyc();
      in_valid = 1'b0;
      smp();
      chk("t2_refill_count", 32'(count), 32'd2);
      chk("t2_fwd_youngest2", fwd_data, 32'h33);
      cyc();
      pop_n(2);
      smp();
      chk("t2_drained", 32'(count), 32'd0);

      // x0 destination never writes or forwards.
      cyc();
      drive(5'd0, 32'h1234, 1'b1);
      enq(5'd0, 32'h1234, 1'b0);
      cyc();
      in_valid = 1'b0;
      fwd_addr = 5'd0;
      smp();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_we_x0", 32'(out_rd_we), 32'd0);
      chk("t3_fwd_x0", 32'(fwd_hit), 32'd0);
      chk("t3_fwd_x0_data", fwd_data, 32'd0);
      cyc();
      pop_n(1);

      // Steady push+pop at count 1; the head being popped still forwards.
      drive(5'd7, 32'h100, 1'b1);
      enq(5'd7, 32'h100, 1'b1);
      prev_addr = 5'd7;
      prev_data = 32'h100;
      cyc();
      for (int i = 1; i <= 10; i++) begin
         drive(5'(8 + i), 32'h100 + 32'(i), 1'b1);
         enq(5'(8 + i), 32'h100 + 32'(i), 1'b1);
         out_ready = 1'b1;
         fwd_addr  = prev_addr;
         smp();
         chk("t4_count", 32'(count), 32'd1);
         chk("t4_fwd_hit_pop", 32'(fwd_hit), 32'd1);
         chk("t4_fwd_data_pop", fwd_data, prev_data);
         prev_addr = 5'(8 + i);
         prev_data = 32'h100 + 32'(i);
         cyc();
      end
      in_valid = 1'b0;
      smp();
      cyc();
      out_ready = 1'b0;
      smp();
      chk("t4_drained", 32'(count), 32'd0);

      // Setback during a push discards everything, pushed data included.
      cyc();
      drive(5'd9, 32'hA1, 1'b1);
      cyc();
      drive(5'd10, 32'hA2, 1'b1);
      cyc();
      drive(5'd11, 32'hA3, 1'b1);
      setback = 1'b1;
      smp();
      chk("t5_pre_count", 32'(count), 32'd2);
      cyc();
      setback  = 1'b0;
      in_valid = 1'b0;
      fwd_addr = 5'd11;
      smp();
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_we", 32'(out_rd_we), 32'd0);
      chk("t5_fwd_hit", 32'(fwd_hit), 32'd0);
      chk("t5_fwd_data", fwd_data, 32'd0);
      chk("t5_hold_data", out_rd_wdata, 32'hA1);
      cyc();
      fwd_addr = 5'd9;
      pop_n(2);
      smp();
      chk("t5_fwd_stale", 32'(fwd_hit), 32'd0);

      // Flush with simultaneous pop and push: the pop is seen, the push is lost.
      cyc();
      drive(5'd12, 32'hB0, 1'b1);
      enq(5'd12, 32'hB0, 1'b1);
      cyc();
      drive(5'd13, 32'hB1, 1'b1);
      out_ready = 1'b1;
      flush     = 1'b1;
      smp();
      cyc();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      smp();
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_valid", 32'(out_valid), 32'd0);

      // Reset mid-operation drops contents and clears held outputs.
      cyc();
      drive(5'd14, 32'hC0, 1'b1);
      cyc();
      in_valid = 1'b0;
      rst      = 1'b1;
      smp();
      chk("t7_count", 32'(count), 32'd0);
      chk("t7_valid", 32'(out_valid), 32'd0);
      chk("t7_data", out_rd_wdata, 32'd0);
      cyc();
      rst = 1'b0;
      smp();
      chk("t7_ready", 32'(in_ready), 32'd1);

`ifdef IBEX_EX_WB_BUFFER_PARITY_EN
      // Corrupt the stored head (slot 0 after reset) and expect a sticky error.
      cyc();
      drive(5'd15, 32'hD0, 1'b1);
      cyc();
      in_valid = 1'b0;
      dut.entries_r[0].data[7] = ~dut.entries_r[0].data[7];
      smp();
      chk("t8_par_not_yet", 32'(parity_err), 32'd0);
      cyc();
      smp();
      chk("t8_par_set", 32'(parity_err), 32'd1);
      cyc();
      cyc();
      smp();
      chk("t8_par_sticky", 32'(parity_err), 32'd1);
      cyc();
      setback = 1'b1;
      cyc();
      setback = 1'b0;
      smp();
      chk("t8_par_cleared", 32'(parity_err), 32'd0);
`endif

      cyc();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ibex_ex_wb_buffer.md
Name: ibex_ex_wb_buffer

Overview:
- Result buffer directly downstream of the execute block.
- Captures each completed EX result (ALU or mult/div, qualified by EX valid) with its destination register.
- Holds it in a small in-order FIFO until the writeback/register-file port accepts it.
- Provides a same-cycle forwarding lookup so decode can bypass buffered results; setback/flush discards speculative entries (lockstep recovery).

Parameters:
- Depth, 2, number of buffer entries; legal values 2 or 4 (power of two).
- AddrW, 5, destination register address width (5 = RV32I, 4 = RV32E).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- setback_i  in  1  lockstep setback; discard all entries
- flush_i  in  1  pipeline flush; discard all entries
- in_valid_i  in  1  EX result valid (driven from ex_valid_o qualified by instruction valid)
- in_ready_o  out  1  buffer can accept
- in_result_i  in  32  EX result
- in_rd_addr_i  in  AddrW  destination register
- in_rd_we_i  in  1  instruction writes rd
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  writeback accepts head
- out_rd_addr_o  out  AddrW  head destination
- out_rd_wdata_o  out  32  head data
- out_rd_we_o  out  1  head write enable
- fwd_addr_i  in  AddrW  lookup address from decode
- fwd_hit_o  out  1  a buffered entry targets fwd_addr_i
- fwd_data_o  out  32  data of youngest matching entry
- count_o  out  $clog2(Depth)+1  occupancy

Behaviour:
- Reset (async, rst_i=1): all entries invalid; rd pointer, wr pointer and count = 0. Outputs: out_valid_o=0, out_rd_we_o=0, out_rd_addr_o=0, out_rd_wdata_o=0, fwd_hit_o=0, fwd_data_o=0, count_o=0, in_ready_o=1 once rst_i deasserts. A reset mid-operation drops all contents.
- Push: in_valid_i & in_ready_o at a clock edge writes an entry at wr_ptr. Stored we = in_rd_we_i & (in_rd_addr_i != 0), so x0 writes are neutralised.
- Pop: out_valid_o & out_ready_i at a clock edge advances rd_ptr.
- Latency: a pushed entry is visible at out_valid_o the next cycle. There is no combinational in->out path.
- in_ready_o = (count < Depth). It does not depend on out_ready_i (no comb ready path).
- Full with simultaneous pop: the push is refused (in_ready_o=0) and the pop proceeds.
- Empty with simultaneous push: the entry appears next cycle.
- Push and pop in the same cycle: count unchanged.
- Pointers: wrap modulo Depth; count is tracked separately, so full and empty are unambiguous.
- Outputs are driven from the head entry. When out_valid_o=0, data/addr are held at the last value and out_rd_we_o is forced to 0.
- Flush/setback:
  - setback_i | flush_i sampled high clears count and pointers at that edge.
  - A push and pop in the same cycle are both discarded; the pop handshake is still seen by writeback, which is the writeback's responsibility.
  - In the cycle after, out_valid_o=0.
  - Flush has priority over push, pop and forwarding state.
- Forwarding (combinational over registered entries):
  - fwd_hit_o=1 iff some valid entry has we=1 and addr==fwd_addr_i, with fwd_addr_i != 0.
  - fwd_data_o is taken from the youngest such entry (closest to wr_ptr); it is 0 when there is no hit.
  - Entries being popped this cycle still count as hits.

Optional Feature:
- Macro IBEX_EX_WB_BUFFER_PARITY_EN.
- Enabled:
  - Each entry stores an odd-parity bit over {we, addr, result}, computed at push.
  - Adds output parity_err_o (1 bit): a registered flag, set one cycle after a valid head entry whose recomputed parity mismatches.
  - The flag is sticky until rst_i or setback_i.
- Disabled: no parity storage and no parity_err_o port.

Decomposition:
- Shared package ibex_pkg: entry struct wb_buf_entry_t {logic we; logic [AddrW-1:0] addr; logic [31:0] data}, plus a parity helper function.
- One natural sub-module, ibex_ex_wb_fwd_mux: youngest-match priority selector over the entry array, given rd_ptr and count.

Test Plan:
- Reset then push {rd=5, data=0xDEADBEEF, we=1}, out_ready_i=0 -> next cycle out_valid_o=1, addr 5, data 0xDEADBEEF, count_o=1; fwd_addr_i=5 gives fwd_hit_o=1, fwd_data_o=0xDEADBEEF.
- Depth=2: push 0x11 (rd=3), push 0x22 (rd=3), out_ready_i=0 -> count_o=2, in_ready_o=0, fwd_data_o=0x22; third push is held off until a pop occurs.
- Push rd=0, data=0x1234, we=1 -> out_rd_we_o=0 at head; fwd_addr_i=0 gives fwd_hit_o=0.
- Full buffer, push and pop in the same cycle -> push refused and count_o=1; steady simultaneous push+pop at count 1 keeps count at 1 over 10 cycles with in-order data.
- Two entries, assert setback_i one cycle during a push -> next cycle count_o=0, out_valid_o=0, fwd_hit_o=0; the pushed data is never emitted.
- With IBEX_EX_WB_BUFFER_PARITY_EN, force-flip stored data bit 7 of the head -> parity_err_o=1 the following cycle, held until setback_i.
